// File: rtl/serial_burst_slave.sv
// serial_burst_slave
// Bit-serial bus slave with a local word memory. A transaction is one header
// (address then len-1, both LSB first on swdata) followed by a burst of words,
// either written into memory from swdata or streamed back on srdata.
// Memory index = addr mod MEM_DEPTH and increments (with wrap) per word.
// Assumes ADDR_WIDTH >= 2, DATA_WIDTH >= 2, MEM_DEPTH >= 2.

module serial_burst_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 256,
    parameter int BURST_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mvalid,
    input  logic smode,
    input  logic swdata,
    output logic srdata,
    output logic svalid,
    output logic sready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    // One shared bit counter serves the address, length and data phases,
    // so it is sized for the widest of the three fields.
    localparam int HDR_W = (ADDR_WIDTH > BURST_WIDTH) ? ADDR_WIDTH : BURST_WIDTH;
    localparam int MAX_W = (HDR_W > DATA_WIDTH) ? HDR_W : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        WDATA,
        RLOAD,
        RDATA
    } state_t;

    state_t state, nstate;

    logic                   mode;      // 1 = write burst, latched on start
    logic [ADDR_WIDTH-1:0]  addr;      // header address, filled MSB-side
    logic [BURST_WIDTH-1:0] lenf;      // len-1 as received
    logic [CNT_W-1:0]       cnt;       // bit position within current field
    logic [BURST_WIDTH-1:0] wcnt;      // word number within the burst
    logic [IDX_W-1:0]       idx;       // memory index of the current word
    logic [DATA_WIDTH-2:0]  wsh;       // write data below the MSB
    logic [DATA_WIDTH-1:0]  rsh;       // read data being shifted out
    logic [DATA_WIDTH-1:0]  pf;        // prefetched next read word

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic start;
    logic addr_last;
    logic len_last;
    logic bit_last;
    logic word_last;
    logic [DATA_WIDTH-1:0] wword;

    // sready is a register that only rises in IDLE, so it alone qualifies
    // the start cycle; the state term guards against any stray overlap.
    assign start     = mvalid && sready && (state == IDLE);
    assign addr_last = (cnt == CNT_W'(ADDR_WIDTH - 1));
    assign len_last  = (cnt == CNT_W'(BURST_WIDTH - 1));
    assign bit_last  = (cnt == CNT_W'(DATA_WIDTH - 1));
    assign word_last = (wcnt == lenf);
    // Word as it will look once the current swdata bit is shifted in.
    assign wword     = {swdata, wsh};

    assign svalid = (state == RDATA);
    assign srdata = (state == RDATA) && rsh[0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state logic; a dropped mvalid outside IDLE always wins.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = ADDR;
            ADDR:    if (addr_last) nstate = LEN;
            LEN:     if (len_last) nstate = mode ? WDATA : RLOAD;
            WDATA:   if (bit_last && word_last) nstate = IDLE;
            RLOAD:   nstate = RDATA;
            RDATA:   if (bit_last && word_last) nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (state != IDLE && !mvalid) nstate = IDLE;
    end

    // Ready is registered: it reflects where the FSM will be next cycle,
    // so a transaction can never start on the edge that ends the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sready <= 1'b0;
        else     sready <= (nstate == IDLE);
    end

    // Header capture, counters and shift registers. Nothing advances while
    // mvalid is low, so an aborted partial word is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= 1'b0;
            addr <= '0;
            lenf <= '0;
            cnt  <= '0;
            wcnt <= '0;
            idx  <= '0;
            wsh  <= '0;
            rsh  <= '0;
            pf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode <= smode;
                        addr <= {swdata, {(ADDR_WIDTH-1){1'b0}}};
                        cnt  <= CNT_W'(1);
                        wcnt <= '0;
                    end
                end
                ADDR: begin
                    if (mvalid) begin
                        addr <= {swdata, addr[ADDR_WIDTH-1:1]};
                        cnt  <= addr_last ? '0 : cnt + 1'b1;
                    end
                end
                LEN: begin
                    if (mvalid) begin
                        lenf <= {swdata, lenf[BURST_WIDTH-1:1]};
                        cnt  <= len_last ? '0 : cnt + 1'b1;
                        // Address is complete by now; upper bits are dropped.
                        if (len_last) idx <= addr[IDX_W-1:0];
                    end
                end
                WDATA: begin
                    if (mvalid) begin
                        wsh <= wword[DATA_WIDTH-1:1];
                        if (bit_last) begin
                            cnt  <= '0;
                            wcnt <= wcnt + 1'b1;
                            idx  <= idx + 1'b1;
                        end else begin
                            cnt  <= cnt + 1'b1;
                        end
                    end
                end
                RLOAD: begin
                    if (mvalid) begin
                        rsh <= mem[idx];
                        idx <= idx + 1'b1;
                        cnt <= '0;
                    end
                end
                RDATA: begin
                    if (mvalid) begin
                        // Fetch the following word at the start of each word
                        // so it is ready to drop in after the current MSB.
                        if (cnt == '0) begin
                            pf  <= mem[idx];
                            idx <= idx + 1'b1;
                        end
                        if (bit_last) begin
                            rsh  <= pf;
                            cnt  <= '0;
                            wcnt <= wcnt + 1'b1;
                        end else begin
                            rsh  <= {1'b0, rsh[DATA_WIDTH-1:1]};
                            cnt  <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory write on the edge that captures a word's MSB; never reset.
    always_ff @(posedge clk) begin
        if (state == WDATA && mvalid && bit_last) mem[idx] <= wword;
    end

endmodule

// File: tb/tb_serial_burst_slave.sv
// Self-checking bench for serial_burst_slave. Inputs change on the falling
// edge, outputs are sampled there too; read data is checked against a
// scoreboard queue filled from a reference memory when each read is issued.

module tb_serial_burst_slave;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst    = 1'b1;
    logic mvalid = 1'b0;
    logic smode  = 1'b0;
    logic swdata = 1'b0;
    logic srdata;
    logic svalid;
    logic sready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model [256];
    logic [7:0] exp_q [$];

    serial_burst_slave dut (
        .clk    (clk),
        .rst    (rst),
        .mvalid (mvalid),
        .smode  (smode),
        .swdata (swdata),
        .srdata (srdata),
        .svalid (svalid),
        .sready (sready)
    );

    // Gated clock so the reset test can freeze it low.
    always #5 if (clk_en) clk = ~clk;

    task automatic wait_ready();
        int k = 0;
        while (!sready && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (sready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ready: sready=%b required 1 (timeout)", sready);
        end
    endtask

    // Drives the 16 header cycles starting on the current cycle (cycle 0).
    // smode is inverted after cycle 0 to show it is only sampled on start.
    task automatic send_header(input logic mode, input logic [11:0] addr,
                               input logic [3:0] lenm1);
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            mvalid = 1'b1;
            smode  = (i == 0) ? mode : ~mode;
            swdata = (i < 12) ? addr[i] : lenm1[i-12];
            if (i > 0 && (sready !== 1'b0 || svalid !== 1'b0)) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL header_busy: %0d cycles with sready/svalid high, required 0", bad);
        end
    endtask

    task automatic write_burst(input logic [11:0] addr, input int len,
                               input logic [63:0] data, input bit hold);
        int bad = 0;
        wait_ready();
        send_header(1'b1, addr, 4'(len - 1));
        for (int b = 0; b < 8 * len; b++) begin
            swdata = data[b];
            if (sready !== 1'b0) bad++;
            @(negedge clk);
        end
        for (int k = 0; k < len; k++) model[8'(addr + 12'(k))] = data[8*k +: 8];
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL write_busy: sready high on %0d data cycles, required 0", bad);
        end
        if (!hold) begin
            mvalid = 1'b0;
            swdata = 1'b0;
        end
        n_checks++;
        if (sready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_done_ready: sready=%b required 1", sready);
        end
    endtask

    task automatic read_burst(input logic [11:0] addr, input int len);
        int         bad = 0;
        logic [7:0] got;
        logic [7:0] exp;
        wait_ready();
        for (int k = 0; k < len; k++) exp_q.push_back(model[8'(addr + 12'(k))]);
        send_header(1'b0, addr, 4'(len - 1));
        // Cycle 16: RLOAD, no valid data yet.
        swdata = 1'($urandom);
        n_checks++;
        if (svalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rload_svalid: svalid=%b required 0", svalid);
        end
        got = '0;
        for (int b = 0; b < 8 * len; b++) begin
            @(negedge clk);
            swdata = 1'($urandom);
            if (svalid !== 1'b1) bad++;
            got[b % 8] = srdata;
            if (b % 8 == 7) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL read_word addr=%03h word %0d: got %02h expected %02h",
                             addr, b / 8, got, exp);
                end
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL read_svalid: %0d data cycles without svalid, required 0", bad);
        end
        @(negedge clk);
        mvalid = 1'b0;
        n_checks++;
        if (svalid !== 1'b0 || sready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_end: svalid=%b sready=%b required 0/1", svalid, sready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sready !== 1'b0 || svalid !== 1'b0 || srdata !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: sready=%b svalid=%b srdata=%b required 0/0/0",
                     sready, svalid, srdata);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (sready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_pre: sready=%b required 0", sready);
        end
        @(negedge clk);
        n_checks++;
        if (sready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_post: sready=%b required 1", sready);
        end
    endtask

    task automatic test_single();
        write_burst(12'h4D5, 1, 64'hD5, 1'b0);
        read_burst(12'h4D5, 1);
    endtask

    task automatic test_burst_wrap();
        write_burst(12'h0FE, 4, 64'h44332211, 1'b0);
        read_burst(12'h0FE, 4);
        read_burst(12'h000, 2);
    endtask

    task automatic test_alias();
        write_burst(12'h305, 1, 64'hA5, 1'b0);
        read_burst(12'h005, 1);
    endtask

    task automatic test_abort();
        logic [63:0] data = 64'h030201;
        write_burst(12'h012, 1, 64'h5C, 1'b0);
        wait_ready();
        send_header(1'b1, 12'h010, 4'd2);
        for (int b = 0; b < 20; b++) begin
            swdata = data[b];
            @(negedge clk);
        end
        mvalid = 1'b0;
        n_checks++;
        if (sready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cycle: sready=%b required 0", sready);
        end
        @(negedge clk);
        n_checks++;
        if (sready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: sready=%b required 1", sready);
        end
        model[8'h10] = 8'h01;
        model[8'h11] = 8'h02;
        read_burst(12'h010, 3);
    endtask

    task automatic test_back_to_back();
        write_burst(12'h040, 2, 64'h6B9A, 1'b1);
        read_burst(12'h040, 2);
    endtask

    task automatic test_reset_mid();
        write_burst(12'h020, 1, 64'hC3, 1'b0);
        wait_ready();
        send_header(1'b0, 12'h020, 4'd1);
        @(negedge clk);                 // first data cycle: bit 0 of 0xC3 = 1
        n_checks++;
        if (svalid !== 1'b1 || srdata !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset: svalid=%b srdata=%b required 1/1", svalid, srdata);
        end
        clk_en = 1'b0;
        rst    = 1'b1;
        #1;
        n_checks++;
        if (sready !== 1'b0 || svalid !== 1'b0 || srdata !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: sready=%b svalid=%b srdata=%b required 0/0/0",
                     sready, svalid, srdata);
        end
        #1;
        rst    = 1'b0;
        mvalid = 1'b0;
        #1;
        n_checks++;
        if (sready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release_pre: sready=%b required 0", sready);
        end
        clk_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release_post: sready=%b required 1", sready);
        end
        read_burst(12'h020, 1);         // memory survives reset
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_alias();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d words left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_burst_slave.md
# serial_burst_slave

Bit-serial bus slave with a parametrised local memory and multi-word burst transfers, attached to the system bus in place of the single-word serial slave. It takes one address and a burst length from the master over the same serial write line (`swdata`), then either stores a burst of words into memory or streams a burst of stored words back on `srdata`. Address width, data width, memory depth and maximum burst length are all parameters. The block adds `sready` back-pressure and a defined abort behaviour when `mvalid` drops mid-transfer.

## Interface
- `ADDR_WIDTH`, 12, width of the serial bus address, sent LSB first.
- `DATA_WIDTH`, 8, width of one memory word, sent and returned LSB first.
- `MEM_DEPTH`, 256, number of words in local memory; must be a power of two and no larger than 2^ADDR_WIDTH.
- `BURST_WIDTH`, 4, width of the burst-length field; the field encodes `len-1`, so bursts are 1 to 2^BURST_WIDTH words.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mvalid`  in  1  master valid; held high for the whole transaction.
- `smode`  in  1  transfer direction, sampled only on the start cycle: 1 = write, 0 = read.
- `swdata`  in  1  serial header and write data from the master.
- `srdata`  out  1  serial read data to the master.
- `svalid`  out  1  high on every cycle where `srdata` carries a valid read bit.
- `sready`  out  1  high only when idle and able to accept a new transaction.

## Operation
FSM states: IDLE, ADDR, LEN, WDATA, RLOAD, RDATA.

- **IDLE**
  - `sready`=1.
  - The start cycle is any cycle with `mvalid`=1 and `sready`=1 (cycle 0).
  - On the start cycle the block latches `smode`, captures `swdata` as address bit 0, and moves to ADDR.
- **ADDR**
  - Captures address bits 1 to ADDR_WIDTH-1, one per cycle.
  - Moves to LEN when done.
- **LEN**
  - Captures BURST_WIDTH bits of `len-1`, LSB first.
  - Then moves to WDATA if `smode` was 1, otherwise RLOAD.
- **Word index**
  - Memory index = `addr mod MEM_DEPTH`; upper address bits are ignored.
  - Each following word in the burst uses index+1, wrapping from MEM_DEPTH-1 to 0.
- **WDATA**
  - Shifts in DATA_WIDTH bits per word.
  - The completed word is written to memory on the edge that captures its MSB.
  - After `len` words, returns to IDLE.
- **RLOAD**
  - One cycle: fetches the first word into the output shift register.
- **RDATA**
  - Drives `svalid`=1 and shifts out `len`×DATA_WIDTH bits with no gaps.
  - The next word is prefetched so there are no bubbles between words.
  - Returns to IDLE after the last bit.
- **Abort**
  - If `mvalid` is 0 in any state other than IDLE, the FSM returns to IDLE on the next edge.
  - A partial word is discarded; words already written stay in memory.
  - `svalid` drops on that same edge.
- **Reset**
  - `rst` at any time forces IDLE immediately, without waiting for a clock edge, and clears all counters and shift registers.
  - Memory contents are not cleared.
- **Start-cycle collisions**
  - In IDLE, `smode` and `swdata` are ignored while `mvalid`=0.
  - A new transaction is not accepted on the same edge that a previous one ends, because `sready` is registered.

## Timing
Let A = ADDR_WIDTH and B = BURST_WIDTH.

- **Reset values**
  - `srdata`=0, `svalid`=0, `sready`=0 while `rst` is high.
  - `sready` rises on the first `clk` edge after `rst` falls.
- **Header**
  - Address bits occupy cycles 0 to A-1.
  - Length bits occupy cycles A to A+B-1.
- **Write**
  - Bit j of word k is sampled at cycle A+B+k·DATA_WIDTH+j.
  - The memory update for word k is visible from the following cycle.
- **Read**
  - Cycle A+B is RLOAD, with `svalid`=0.
  - `svalid`=1 from cycle A+B+1 through A+B+len·DATA_WIDTH.
  - `srdata` at cycle A+B+1+k·DATA_WIDTH+j = bit j of word k.
- **Return to idle**
  - `sready` is 0 from the cycle after the start cycle until the cycle after the last data bit (write or read), or the cycle after an abort.
  - It is 1 from then on.
- **Data hold**
  - Outside RDATA, `srdata` is held at 0.

## Test plan
All scenarios use the default parameters.

- **Reset** — assert `rst` mid-transfer with `clk` stopped → `sready`, `svalid` and `srdata` all read 0 immediately; `sready`=1 one edge after release.
- **Single-word write then read** — write addr 0x4D5, len 1, data 0xD5; then read 0x4D5, len 1 → `svalid` high for exactly 8 cycles starting 17 cycles after the read start cycle; the bits assemble to 0xD5.
- **Burst with wrap** — write addr 0x0FE, len 4, data 0x11, 0x22, 0x33, 0x44; read addr 0x0FE, len 4 → 32 contiguous valid bits 0x11, 0x22, 0x33, 0x44. A read of addr 0x000, len 2 then returns 0x33, 0x44, showing the index wraps from 255 to 0.
- **Alias** — write 0xA5 to addr 0x305, then read addr 0x005 → 0xA5, because upper address bits are ignored.
- **Abort** — write burst len 3 to addr 0x010 with 0x01, 0x02, then drop `mvalid` after 4 bits of the third word → returns to IDLE, `sready`=1 one cycle later. A later read of 0x010, len 3 returns 0x01, 0x02 and the old contents at 0x012.
- **Back-to-back** — hold `mvalid` high across the end of a write → the new start is taken only on the first cycle where `sready`=1; there is no overlap with the previous transfer.
